// File: rtl/lr_traffic_monitor.sv
// -----------------------------------------------------------------------------
// lr_traffic_monitor
//
// Watches a highway / local-road light pair and the local-road car queue.
//   * Queue side: counts cars waiting on the local road (0..15) and the total
//     number of cars that have departed (8-bit, wrapping). A car departs every
//     second cycle of local-road green while the queue is non-empty.
//   * Light side: a phase FSM follows the legal light sequence and latches the
//     first rule violation it sees (sticky until reset).
//
// Ports
//   clk          in   1  single clock, all state on posedge
//   rst_n        in   1  synchronous active-low reset
//   car_arrive   in   1  one-cycle pulse, one car joins the queue
//   hw_light     in   3  highway light, one-hot G=100 Y=010 R=001
//   lr_light     in   3  local-road light, same encoding
//   lr_has_car   out  1  queue non-empty (combinational from car_count)
//   car_count    out  4  queue occupancy
//   cars_passed  out  8  departed cars, wraps 255->0
//   overflow     out  1  sticky, an arrival was dropped at a full queue
//   violation    out  1  sticky, a light-sequence rule was broken
//   err_code     out  3  code of the first violation, 0 = none
//   dbg_state    out  3  current phase FSM state (phase_e encoding)
//
// Input contract: there is no handshake. car_arrive is an unqualified pulse
// that is accepted in the cycle it is high, and both lights are sampled every
// cycle; the monitor can never stall its environment.
// -----------------------------------------------------------------------------
module lr_traffic_monitor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_arrive,
    input  logic [2:0] hw_light,
    input  logic [2:0] lr_light,
    output logic       lr_has_car,
    output logic [3:0] car_count,
    output logic [7:0] cars_passed,
    output logic       overflow,
    output logic       violation,
    output logic [2:0] err_code,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] LIGHT_G = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_R = 3'b001;

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        HW_GO   = 3'd1,
        HW_WARN = 3'd2,
        RED_A   = 3'd3,
        LR_GO   = 3'd4,
        LR_WARN = 3'd5,
        RED_B   = 3'd6,
        ERR     = 3'd7
    } phase_e;

    // Light pair {hw, lr} that belongs to each sequencing state.
    function automatic logic [5:0] phase_lights(input phase_e s);
        case (s)
            HW_GO:   phase_lights = {LIGHT_G, LIGHT_R};
            HW_WARN: phase_lights = {LIGHT_Y, LIGHT_R};
            RED_A:   phase_lights = {LIGHT_R, LIGHT_R};
            LR_GO:   phase_lights = {LIGHT_R, LIGHT_G};
            LR_WARN: phase_lights = {LIGHT_R, LIGHT_Y};
            RED_B:   phase_lights = {LIGHT_R, LIGHT_R};
            default: phase_lights = 6'b000000;
        endcase
    endfunction

    function automatic phase_e phase_succ(input phase_e s);
        case (s)
            HW_GO:   phase_succ = HW_WARN;
            HW_WARN: phase_succ = RED_A;
            RED_A:   phase_succ = LR_GO;
            LR_GO:   phase_succ = LR_WARN;
            LR_WARN: phase_succ = RED_B;
            RED_B:   phase_succ = HW_GO;
            default: phase_succ = s;
        endcase
    endfunction

    // ---------------------------------------------------------------- state
    phase_e      state_q, state_d;
    logic [7:0]  phase_cnt_q, phase_cnt_d;
    logic        depart_tmr_q, depart_tmr_d;
    logic [3:0]  car_count_q, car_count_d;
    logic [7:0]  cars_passed_q, cars_passed_d;
    logic        overflow_q, overflow_d;
    logic        violation_q, violation_d;
    logic [2:0]  err_code_q, err_code_d;

    // ---------------------------------------------------------------- queue
    logic lr_green;
    logic departure;

    always_comb begin
        lr_green      = (lr_light == LIGHT_G);
        // Timer alternates 0/1 through a green run, so cars leave on the
        // 2nd, 4th, 6th ... green cycle.
        depart_tmr_d  = lr_green ? ~depart_tmr_q : 1'b0;
        departure     = lr_green && depart_tmr_q && (car_count_q != 4'd0);

        car_count_d   = car_count_q;
        cars_passed_d = cars_passed_q;
        overflow_d    = overflow_q;

        if (departure) begin
            cars_passed_d = cars_passed_q + 8'd1;
            if (!car_arrive) begin
                car_count_d = car_count_q - 4'd1;
            end
        end else if (car_arrive) begin
            if (car_count_q == 4'd15) begin
                overflow_d = 1'b1;
            end else begin
                car_count_d = car_count_q + 4'd1;
            end
        end
    end

    // ---------------------------------------------------------------- checks
    logic       hw_legal, lr_legal;
    logic       checks_on;
    logic [5:0] pair;
    logic       match_cur, match_nxt, leaving;
    logic       err1, err2, err3, err4, err5, err6, err7;
    logic [2:0] new_code;

    always_comb begin
        hw_legal  = (hw_light == LIGHT_G) || (hw_light == LIGHT_Y) || (hw_light == LIGHT_R);
        lr_legal  = (lr_light == LIGHT_G) || (lr_light == LIGHT_Y) || (lr_light == LIGHT_R);
        // Sequence checks only mean something once the FSM is locked to the
        // lights; SYNC only rejects illegal encodings, ERR checks nothing.
        checks_on = (state_q != SYNC) && (state_q != ERR);
        pair      = {hw_light, lr_light};
        match_cur = (pair == phase_lights(state_q));
        match_nxt = (pair == phase_lights(phase_succ(state_q)));
        leaving   = checks_on && !match_cur && match_nxt;

        err1 = (state_q != ERR) && (!hw_legal || !lr_legal);
        err2 = checks_on && (hw_light != LIGHT_R) && (lr_light != LIGHT_R);
        err3 = checks_on && !match_cur && !match_nxt;
        err4 = leaving && ((state_q == HW_WARN) || (state_q == LR_WARN))
               && (phase_cnt_q != 8'd25);
        err5 = leaving && ((state_q == RED_A) || (state_q == RED_B))
               && (phase_cnt_q != 8'd1);
        err6 = leaving && (state_q == LR_GO) && (phase_cnt_q != 8'd70);
        err7 = leaving && (state_q == HW_GO) && (phase_cnt_q < 8'd70);

        // Lowest code wins when several rules break in the same cycle.
        if      (err1) new_code = 3'd1;
        else if (err2) new_code = 3'd2;
        else if (err3) new_code = 3'd3;
        else if (err4) new_code = 3'd4;
        else if (err5) new_code = 3'd5;
        else if (err6) new_code = 3'd6;
        else if (err7) new_code = 3'd7;
        else           new_code = 3'd0;
    end

    // ---------------------------------------------------------------- phase FSM
    always_comb begin
        state_d     = state_q;
        violation_d = violation_q;
        err_code_d  = err_code_q;

        if (new_code != 3'd0) begin
            state_d     = ERR;
            violation_d = 1'b1;
            err_code_d  = new_code;
        end else if (state_q == SYNC) begin
            if (pair == {LIGHT_G, LIGHT_R}) begin
                state_d = HW_GO;
            end
        end else if (leaving) begin
            state_d = phase_succ(state_q);
        end

        // Counts cycles spent in the current state, including this one.
        if (state_d != state_q) begin
            phase_cnt_d = 8'd1;
        end else if (phase_cnt_q == 8'd255) begin
            phase_cnt_d = 8'd255;
        end else begin
            phase_cnt_d = phase_cnt_q + 8'd1;
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= SYNC;
            phase_cnt_q   <= 8'd0;
            depart_tmr_q  <= 1'b0;
            car_count_q   <= 4'd0;
            cars_passed_q <= 8'd0;
            overflow_q    <= 1'b0;
            violation_q   <= 1'b0;
            err_code_q    <= 3'd0;
        end else begin
            state_q       <= state_d;
            phase_cnt_q   <= phase_cnt_d;
            depart_tmr_q  <= depart_tmr_d;
            car_count_q   <= car_count_d;
            cars_passed_q <= cars_passed_d;
            overflow_q    <= overflow_d;
            violation_q   <= violation_d;
            err_code_q    <= err_code_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign lr_has_car  = (car_count_q != 4'd0);
    assign car_count   = car_count_q;
    assign cars_passed = cars_passed_q;
    assign overflow    = overflow_q;
    assign violation   = violation_q;
    assign err_code    = err_code_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lr_traffic_monitor.sv
// -----------------------------------------------------------------------------
// tb_lr_traffic_monitor
//
// Directed bench. Driver tasks apply one cycle of lights/arrival at a time and
// push the hand-computed expected outputs after each edge; a monitor on the
// falling edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_lr_traffic_monitor;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    localparam int S_SYNC    = 0;
    localparam int S_HW_GO   = 1;
    localparam int S_HW_WARN = 2;
    localparam int S_RED_A   = 3;
    localparam int S_LR_GO   = 4;
    localparam int S_LR_WARN = 5;
    localparam int S_RED_B   = 6;
    localparam int S_ERR     = 7;

    localparam int W = 21;

    // ------------------------------------------------------------ clock/reset
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_arrive = 1'b0;
    logic [2:0] hw_light = R;
    logic [2:0] lr_light = R;
    logic       lr_has_car;
    logic [3:0] car_count;
    logic [7:0] cars_passed;
    logic       overflow;
    logic       violation;
    logic [2:0] err_code;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    lr_traffic_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .car_arrive  (car_arrive),
        .hw_light    (hw_light),
        .lr_light    (lr_light),
        .lr_has_car  (lr_has_car),
        .car_count   (car_count),
        .cars_passed (cars_passed),
        .overflow    (overflow),
        .violation   (violation),
        .err_code    (err_code),
        .dbg_state   (dbg_state)
    );

    // ------------------------------------------------------------ scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    logic [W-1:0] act;
    assign act = {lr_has_car, car_count, cars_passed, overflow, violation, err_code, dbg_state};

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got has=%0b cnt=%0d passed=%0d ovf=%0b viol=%0b code=%0d st=%0d, want has=%0b cnt=%0d passed=%0d ovf=%0b viol=%0b code=%0d st=%0d",
                         n, act[20], act[19:16], act[15:8], act[7], act[6], act[5:3], act[2:0],
                         e[20], e[19:16], e[15:8], e[7], e[6], e[5:3], e[2:0]);
            end
        end
    end

    // ------------------------------------------------------------ driver tasks
    task automatic cyc(input logic [2:0] hw, input logic [2:0] lr, input logic arr);
        hw_light   = hw;
        lr_light   = lr;
        car_arrive = arr;
        @(posedge clk);
        #1;
        car_arrive = 1'b0;
    endtask

    task automatic phase(input logic [2:0] hw, input logic [2:0] lr, input int n);
        repeat (n) cyc(hw, lr, 1'b0);
    endtask

    // Reset is held across arrivals and bad lights to show it overrides them.
    task automatic do_reset();
        rst_n = 1'b0;
        cyc(G, G, 1'b1);
        cyc(3'b111, R, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string nm, input int cc, input int cp,
                              input logic ov, input logic vi, input int ec, input int st);
        logic [3:0] cc4;
        logic [7:0] cp8;
        logic [2:0] ec3;
        logic [2:0] st3;
        cc4 = cc[3:0];
        cp8 = cp[7:0];
        ec3 = ec[2:0];
        st3 = st[2:0];
        exp_q.push_back({(cc != 0), cc4, cp8, ov, vi, ec3, st3});
        name_q.push_back(nm);
    endtask

    // ------------------------------------------------------------ stimulus
    int ecc[6] = '{3, 2, 2, 1, 1, 0};
    int ecp[6] = '{0, 1, 1, 2, 2, 3};

    initial begin
        do_reset();
        expect_out("reset", 0, 0, 0, 0, 0, S_SYNC);

        // Three arrivals with the local road red.
        repeat (3) cyc(R, R, 1'b1);
        expect_out("arrive3", 3, 0, 0, 0, 0, S_SYNC);

        // Green run: departures on green cycles 2, 4 and 6.
        for (int i = 0; i < 6; i++) begin
            cyc(R, G, 1'b0);
            expect_out($sformatf("green_cycle%0d", i + 1), ecc[i], ecp[i], 0, 0, 0, S_SYNC);
        end

        // Fill and overflow.
        do_reset();
        repeat (15) cyc(R, R, 1'b1);
        expect_out("fill15", 15, 0, 0, 0, 0, S_SYNC);
        cyc(R, R, 1'b1);
        expect_out("arrival16_dropped", 15, 0, 1, 0, 0, S_SYNC);
        cyc(R, R, 1'b1);
        expect_out("arrival17_dropped", 15, 0, 1, 0, 0, S_SYNC);
        cyc(R, G, 1'b0);
        expect_out("full_green1", 15, 0, 1, 0, 0, S_SYNC);
        cyc(R, G, 1'b1);
        expect_out("arrive_and_depart_full", 15, 1, 1, 0, 0, S_SYNC);
        cyc(R, G, 1'b0);
        expect_out("full_green3", 15, 1, 1, 0, 0, S_SYNC);
        cyc(R, G, 1'b0);
        expect_out("full_green4_depart", 14, 2, 1, 0, 0, S_SYNC);

        // Two full legal cycles.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            phase(G, R, 70);
            expect_out($sformatf("legal%0d_hw_go", k), 0, 0, 0, 0, 0, S_HW_GO);
            phase(Y, R, 25);
            expect_out($sformatf("legal%0d_hw_warn", k), 0, 0, 0, 0, 0, S_HW_WARN);
            phase(R, R, 1);
            expect_out($sformatf("legal%0d_red_a", k), 0, 0, 0, 0, 0, S_RED_A);
            phase(R, G, 70);
            expect_out($sformatf("legal%0d_lr_go", k), 0, 0, 0, 0, 0, S_LR_GO);
            phase(R, Y, 25);
            expect_out($sformatf("legal%0d_lr_warn", k), 0, 0, 0, 0, 0, S_LR_WARN);
            phase(R, R, 1);
            expect_out($sformatf("legal%0d_red_b", k), 0, 0, 0, 0, 0, S_RED_B);
        end

        // Highway yellow one cycle short.
        do_reset();
        phase(G, R, 70);
        phase(Y, R, 24);
        expect_out("yellow24", 0, 0, 0, 0, 0, S_HW_WARN);
        cyc(R, R, 1'b0);
        expect_out("short_yellow_err4", 0, 0, 0, 1, 4, S_ERR);
        phase(G, R, 3);
        expect_out("err4_holds", 0, 0, 0, 1, 4, S_ERR);
        cyc(R, R, 1'b1);
        expect_out("count_in_err", 1, 0, 0, 1, 4, S_ERR);

        // Highway green too short.
        do_reset();
        phase(G, R, 69);
        cyc(Y, R, 1'b0);
        expect_out("short_hw_go_err7", 0, 0, 0, 1, 7, S_ERR);

        // All-red held two cycles.
        do_reset();
        phase(G, R, 70);
        phase(Y, R, 25);
        phase(R, R, 2);
        expect_out("red_a_held", 0, 0, 0, 0, 0, S_RED_A);
        cyc(R, G, 1'b0);
        expect_out("long_red_err5", 0, 0, 0, 1, 5, S_ERR);

        // Local green one cycle too long.
        do_reset();
        phase(G, R, 70);
        phase(Y, R, 25);
        phase(R, R, 1);
        phase(R, G, 71);
        expect_out("lr_go_71", 0, 0, 0, 0, 0, S_LR_GO);
        cyc(R, Y, 1'b0);
        expect_out("long_lr_go_err6", 0, 0, 0, 1, 6, S_ERR);

        // Out-of-order pair from HW_GO.
        do_reset();
        cyc(G, R, 1'b0);
        cyc(R, G, 1'b0);
        expect_out("skip_err3", 0, 0, 0, 1, 3, S_ERR);

        // Illegal encoding while still in SYNC.
        do_reset();
        cyc(3'b000, R, 1'b0);
        expect_out("illegal_in_sync_err1", 0, 0, 0, 1, 1, S_ERR);

        // Codes 1, 2 and 3 together: lowest recorded.
        do_reset();
        cyc(G, R, 1'b0);
        cyc(3'b110, G, 1'b0);
        expect_out("multi_err_lowest", 0, 0, 0, 1, 1, S_ERR);

        // Both green, then illegal, then reset from ERR.
        do_reset();
        cyc(G, R, 1'b0);
        cyc(G, G, 1'b0);
        expect_out("both_green_err2", 0, 0, 0, 1, 2, S_ERR);
        cyc(3'b011, R, 1'b1);
        expect_out("err2_sticky", 1, 0, 0, 1, 2, S_ERR);
        rst_n = 1'b0;
        cyc(G, G, 1'b1);
        rst_n = 1'b1;
        expect_out("reset_from_err", 0, 0, 0, 0, 0, S_SYNC);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
